// File: rtl/control_cmd_rect.sv
// control_cmd_rect: captures a filled/outlined rectangle command byte-by-byte and
// streams its colour bytes into the framebuffer. Optional macro CMD_RECT_CLIP_EN clips to the panel.
`default_nettype none

module control_cmd_rect #(
    parameter int COL_BITS        = 7,
    parameter int ROW_BITS        = 5,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int PANEL_WIDTH     = 64,
    parameter int PANEL_HEIGHT    = 32,
    localparam int PIX_W          = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data_in,
    input  logic                enable,
    output logic [ROW_BITS-1:0] row,
    output logic [COL_BITS-1:0] col,
    output logic [PIX_W-1:0]    pixel,
    output logic [7:0]          data_out,
    output logic                ram_write_enable,
    output logic                ram_access_start,
    output logic                ready_for_data,
    output logic                done
);

    localparam int COL_BYTES = (COL_BITS + 7) / 8;
    localparam int CB_W      = 8 * COL_BYTES;
    localparam int CLR_W     = 8 * BYTES_PER_PIXEL;

    localparam logic [COL_BITS:0] COL_ONE  = 1;
    localparam logic [ROW_BITS:0] ROW_ONE  = 1;
    localparam logic [PIX_W-1:0]  PIX_ONE  = 1;
    localparam logic [PIX_W-1:0]  PIX_TOP  = PIX_W'(BYTES_PER_PIXEL - 1);
    localparam logic [2:0]        CB_LAST  = 3'(COL_BYTES - 1);
    localparam logic [2:0]        CLR_LAST = 3'(BYTES_PER_PIXEL - 1);

    typedef enum logic [3:0] {
        S_MODE, S_X1, S_Y1, S_W, S_H, S_COLOR, S_SETUP, S_RUN, S_DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]          cnt;
    logic                outline;
    logic [CB_W-1:0]     x1_raw, w_raw, x1_next, w_next;
    logic [7:0]          y1_raw, h_raw;
    logic [CLR_W-1:0]    colour, colour_next;
    logic [COL_BITS:0]   cur_col;
    logic [ROW_BITS:0]   cur_row;
    logic [PIX_W-1:0]    cur_pix;
    logic                first;

    logic                accept, field_last;
    logic [COL_BITS:0]   x1, wd, right, last_col;
    logic [ROW_BITS:0]   y1, ht, bottom, last_row;
    logic                zero_size, empty, jump_ok;
    logic                interior, skip_jump, row_end, rect_end;
    logic                unused_bits;

    // Multi-byte fields shift in: x1/width little-endian, colour big-endian.
    if (COL_BYTES == 1) begin : g_cb_one
        assign x1_next = data_in;
        assign w_next  = data_in;
    end else begin : g_cb_multi
        assign x1_next = {data_in, x1_raw[CB_W-1:8]};
        assign w_next  = {data_in, w_raw[CB_W-1:8]};
    end

    if (BYTES_PER_PIXEL == 1) begin : g_clr_one
        assign colour_next = data_in;
    end else begin : g_clr_multi
        assign colour_next = {colour[CLR_W-9:0], data_in};
    end

    assign unused_bits = ^{x1_raw, w_raw, y1_raw, h_raw};

    assign x1        = {1'b0, x1_raw[COL_BITS-1:0]};
    assign wd        = {1'b0, w_raw[COL_BITS-1:0]};
    assign y1        = {1'b0, y1_raw[ROW_BITS-1:0]};
    assign ht        = {1'b0, h_raw[ROW_BITS-1:0]};
    assign right     = x1 + wd - COL_ONE;
    assign bottom    = y1 + ht - ROW_ONE;
    assign zero_size = (wd == '0) || (ht == '0);

`ifdef CMD_RECT_CLIP_EN
    localparam logic [COL_BITS:0] PW_C = (COL_BITS + 1)'(PANEL_WIDTH);
    localparam logic [ROW_BITS:0] PH_C = (ROW_BITS + 1)'(PANEL_HEIGHT);

    assign jump_ok  = (right < PW_C);
    assign last_col = jump_ok ? right : (PW_C - COL_ONE);
    assign last_row = (bottom < PH_C) ? bottom : (PH_C - ROW_ONE);
    assign empty    = zero_size || (x1 >= PW_C) || (y1 >= PH_C);
`else
    assign jump_ok  = 1'b1;
    assign last_col = right;
    assign last_row = bottom;
    assign empty    = zero_size;
`endif

    // An interior outline row ends early when its right edge lies off-panel.
    assign interior  = (cur_row != y1) && (cur_row != bottom);
    assign skip_jump = outline && interior && (cur_col == x1);
    assign row_end   = (cur_col == last_col) || (skip_jump && !jump_ok);
    assign rect_end  = (cur_pix == '0) && row_end && (cur_row == last_row);

    assign ready_for_data = (state == S_MODE) || (state == S_X1) || (state == S_Y1) ||
                            (state == S_W) || (state == S_H) || (state == S_COLOR);
    assign accept         = enable && ready_for_data;

    always_comb begin
        field_last = 1'b1;
        case (state)
            S_X1, S_W: field_last = (cnt == CB_LAST);
            S_COLOR:   field_last = (cnt == CLR_LAST);
            default:   field_last = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_MODE:  if (accept) state_next = S_X1;
            S_X1:    if (accept && field_last) state_next = S_Y1;
            S_Y1:    if (accept) state_next = S_W;
            S_W:     if (accept && field_last) state_next = S_H;
            S_H:     if (accept) state_next = S_COLOR;
            S_COLOR: if (accept && field_last) state_next = S_SETUP;
            S_SETUP: state_next = empty ? S_DONE : S_RUN;
            S_RUN:   if (rect_end) state_next = S_DONE;
            S_DONE:  state_next = S_MODE;
            default: state_next = S_MODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_DONE) begin
            state   <= reset ? S_MODE : state_next;
            cnt     <= '0;
            outline <= 1'b0;
            x1_raw  <= '0;
            w_raw   <= '0;
            y1_raw  <= '0;
            h_raw   <= '0;
            colour  <= '0;
            cur_col <= '0;
            cur_row <= '0;
            cur_pix <= '0;
            first   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= field_last ? 3'd0 : cnt + 3'd1;
                case (state)
                    S_MODE:  outline <= data_in[0];
                    S_X1:    x1_raw  <= x1_next;
                    S_Y1:    y1_raw  <= data_in;
                    S_W:     w_raw   <= w_next;
                    S_H:     h_raw   <= data_in;
                    S_COLOR: colour  <= colour_next;
                    default: ;
                endcase
            end
            if (state == S_SETUP) begin
                cur_row <= y1;
                cur_col <= x1;
                cur_pix <= PIX_TOP;
                first   <= 1'b1;
            end else if (state == S_RUN) begin
                first <= 1'b0;
                if (cur_pix != '0) begin
                    cur_pix <= cur_pix - PIX_ONE;
                end else begin
                    cur_pix <= PIX_TOP;
                    if (row_end) begin
                        cur_col <= x1;
                        cur_row <= cur_row + ROW_ONE;
                    end else if (skip_jump) begin
                        cur_col <= right;
                    end else begin
                        cur_col <= cur_col + COL_ONE;
                    end
                end
            end
        end
    end

    assign ram_write_enable = (state == S_RUN);
    assign ram_access_start = (state == S_RUN) && first;
    assign done             = (state == S_DONE);
    assign row              = cur_row[ROW_BITS-1:0];
    assign col              = cur_col[COL_BITS-1:0];
    assign pixel            = cur_pix;
    assign data_out         = (state == S_RUN) ? colour[{cur_pix, 3'b000} +: 8] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_control_cmd_rect.sv
// Scoreboard bench for control_cmd_rect: a rectangle model queues expected writes.
`default_nettype none

module tb_control_cmd_rect;

    localparam int COL_BITS = 7;
    localparam int ROW_BITS = 5;
    localparam int BPP      = 2;
    localparam int PW       = 64;
    localparam int PH       = 32;
    localparam int CB       = (COL_BITS + 7) / 8;
    localparam int PIX_W    = (BPP > 1) ? $clog2(BPP) : 1;
`ifdef CMD_RECT_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          data_in = 8'h00;
    logic                enable = 1'b0;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;
    logic [PIX_W-1:0]    pixel;
    logic [7:0]          data_out;
    logic                ram_write_enable, ram_access_start, ready_for_data, done;

    control_cmd_rect #(
        .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .BYTES_PER_PIXEL(BPP),
        .PANEL_WIDTH(PW), .PANEL_HEIGHT(PH)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .enable(enable),
        .row(row), .col(col), .pixel(pixel), .data_out(data_out),
        .ram_write_enable(ram_write_enable), .ram_access_start(ram_access_start),
        .ready_for_data(ready_for_data), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int writes_seen = 0;
    int done_count = 0;
    int last_write_cycle = 0;
    int done_cycle = 0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [39:0] pack(input logic s, input logic [7:0] r, input logic [7:0] c,
                                         input logic [7:0] p, input logic [7:0] d);
        return {7'b0, s, r, c, p, d};
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        if (ram_write_enable) begin
            writes_seen++;
            last_write_cycle = cycle;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                check("write", pack(ram_access_start, 8'(row), 8'(col), 8'(pixel), data_out),
                      exp_q.pop_front());
            end
        end
    end

    // Reference rectangle: row-major, ascending columns, pixel bytes high to low.
    function automatic int push_model(input logic [7:0] mode, input int x1, input int y1,
                                      input int w, input int h, input logic [31:0] clr);
        int n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (mode[0] && !(r == 0 || r == h - 1 || c == 0 || c == w - 1)) continue;
                if (CLIP && (x1 + c >= PW || y1 + r >= PH)) continue;
                for (int p = BPP - 1; p >= 0; p--) begin
                    exp_q.push_back(pack(n == 0, 8'((y1 + r) % (1 << ROW_BITS)),
                                         8'((x1 + c) % (1 << COL_BITS)), 8'(p), 8'(clr >> (8 * p))));
                    n++;
                end
            end
        end
        return n;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic send_cmd(input logic [7:0] mode, input int x1, input int y1,
                            input int w, input int h, input logic [31:0] clr);
        int g = 0;
        while (!ready_for_data && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_cmd", ready_for_data, 1);
        send_byte(mode);
        for (int i = 0; i < CB; i++) send_byte(8'(x1 >> (8 * i)));
        send_byte(8'(y1));
        for (int i = 0; i < CB; i++) send_byte(8'(w >> (8 * i)));
        send_byte(8'(h));
        for (int i = BPP - 1; i >= 0; i--) send_byte(8'(clr >> (8 * i)));
    endtask

    task automatic run_cmd(input logic [7:0] mode, input int x1, input int y1, input int w,
                           input int h, input logic [31:0] clr, input bit noise);
        int n, w0, dc0, g;
        w0  = writes_seen;
        dc0 = done_count;
        n   = push_model(mode, x1, y1, w, h, clr);
        send_cmd(mode, x1, y1, w, h, clr);
        @(negedge clk);
        #1;
        check("setup_ready", ready_for_data, 0);
        check("setup_we", ram_write_enable, 0);
        if (n > 0) begin
            @(negedge clk);
            #1;
            check("first_write_latency", {ram_write_enable, ram_access_start}, 2'b11);
        end
        g = 0;
        while (done_count == dc0 && g < 3000) begin
            if (noise) begin
                enable  = 1'($urandom_range(0, 1));
                data_in = 8'($urandom);
            end
            @(negedge clk);
            #1;
            g++;
        end
        enable  = 1'b0;
        data_in = 8'h00;
        if (done_count == dc0) check("done_timeout", 1, 0);
        check("write_count", writes_seen - w0, n);
        check("queue_empty", exp_q.size(), 0);
        if (n > 0) check("done_after_last_write", done_cycle - last_write_cycle, 1);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("ready_after_done", ready_for_data, 1);
        exp_q.delete();
    endtask

    initial begin
        int w0, dc0, g;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", ready_for_data, 1);
        check("reset_flags", {done, ram_write_enable, ram_access_start}, 3'b000);
        check("reset_addr", {8'(row), 8'(col), 8'(pixel), data_out}, 32'h0);
        reset = 1'b0;

        run_cmd(8'h00, 2, 3, 2, 2, 32'hABCD, 1'b0);
        run_cmd(8'h01, 0, 0, 3, 3, 32'h1234, 1'b0);
        run_cmd(8'h00, 10, 4, 0, 5, 32'h5555, 1'b0);
        run_cmd(8'h00, 62, 0, 4, 1, 32'hBEEF, 1'b0);
        run_cmd(8'hFF, 5, 2, 1, 4, 32'h0F0F, 1'b0);
        run_cmd(8'h01, 7, 9, 4, 1, 32'h3C3C, 1'b0);
        run_cmd(8'h01, 60, 28, 6, 5, 32'hC0DE, 1'b0);
        run_cmd(8'h00, 1, 1, 3, 2, 32'h8181, 1'b1);

        // Abort a running fill after its third write.
        w0  = writes_seen;
        dc0 = done_count;
        void'(push_model(8'h00, 2, 3, 2, 2, 32'h7788));
        send_cmd(8'h00, 2, 3, 2, 2, 32'h7788);
        g = 0;
        while (writes_seen - w0 < 3 && g < 100) begin
            @(negedge clk);
            #1;
            g++;
        end
        check("abort_reached_third", writes_seen - w0, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_we", ram_write_enable, 0);
        check("abort_ready", ready_for_data, 1);
        check("abort_left", exp_q.size(), 5);
        exp_q.delete();
        repeat (6) @(negedge clk);
        check("abort_no_done", done_count - dc0, 0);
        check("abort_no_writes", writes_seen - w0, 3);

        run_cmd(8'h00, 2, 3, 2, 2, 32'hABCD, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_cmd(8'($urandom_range(0, 3)), $urandom_range(0, 127), $urandom_range(0, 31),
                    $urandom_range(0, 5), $urandom_range(0, 4), $urandom, 1'(i % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_cmd_rect.md
CONTROL_CMD_RECT -- requirements
Module: control_cmd_rect

Interface
REQ-001 SHALL have parameter COL_BITS, default 7, column address width.
REQ-002 SHALL have parameter ROW_BITS, default 5, row address width.
REQ-003 SHALL have parameter BYTES_PER_PIXEL, default 2, colour bytes per pixel (1..4).
REQ-004 SHALL have parameters PANEL_WIDTH, default 64, and PANEL_HEIGHT, default 32, visible panel extent.
REQ-005 SHALL derive COL_BYTES = ceil(COL_BITS/8), the byte count of the x1 and width fields.
REQ-006 clk  in  1  single clock for all logic.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 data_in  in  8  command parameter byte.
REQ-009 enable  in  1  data_in valid this cycle.
REQ-010 row  out  ROW_BITS  framebuffer row address.
REQ-011 col  out  COL_BITS  framebuffer column address.
REQ-012 pixel  out  clog2(BYTES_PER_PIXEL)  byte index within pixel.
REQ-013 data_out  out  8  colour byte to write.
REQ-014 ram_write_enable  out  1  write strobe, one byte per cycle.
REQ-015 ram_access_start  out  1  high on the first write cycle of a command only.
REQ-016 ready_for_data  out  1  module accepts parameter bytes.
REQ-017 done  out  1  one-cycle pulse at command completion.

Function
REQ-018 Capture order SHALL be: mode (1 byte), x1 (COL_BYTES, little-endian), y1 (1 byte), width (COL_BYTES, LE), height (1 byte), colour (BYTES_PER_PIXEL, big-endian: first byte to index BYTES_PER_PIXEL-1).
REQ-019 Each field SHALL advance only on enable=1; excess bits beyond COL_BITS/ROW_BITS SHALL be truncated.
REQ-020 States SHALL be MODE, X1, Y1, W, H, COLOR, SETUP, RUN, DONE; after the last colour byte SHALL go to SETUP and drop ready_for_data the next cycle.
REQ-021 mode bit0: 0=FILL (every pixel), 1=OUTLINE (only pixels with row==y1, row==y1+h-1, col==x1 or col==x1+w-1); bits 7:1 ignored.
REQ-022 RUN SHALL scan row-major: rows y1..y1+h-1, columns ascending x1..x1+w-1, pixel index BYTES_PER_PIXEL-1 down to 0, one byte per cycle, data_out = colour byte [pixel].
REQ-023 OUTLINE interior pixels SHALL be skipped with no write and no idle cycle (next column jump to x1+w-1).
REQ-024 Latency: first write SHALL occur 2 cycles after the final colour byte is accepted.
REQ-025 width==0 or height==0 SHALL produce no writes and go directly SETUP->DONE.
REQ-026 w==1 or h==1 in OUTLINE SHALL behave as FILL with no duplicate writes.
REQ-027 Coordinate sums SHALL be computed at COL_BITS+1 / ROW_BITS+1 width; without clipping, addresses wrap modulo 2^COL_BITS / 2^ROW_BITS.
REQ-028 DONE SHALL pulse done for exactly one cycle, reassert ready_for_data, clear all fields, return to MODE.
REQ-029 enable while ready_for_data=0 SHALL be ignored.
REQ-030 ram_write_enable SHALL be low in all states except RUN write cycles.

Reset
REQ-031 On reset: state MODE, ready_for_data=1, done=0, ram_write_enable=0, ram_access_start=0, row/col/pixel/data_out=0, all fields cleared.
REQ-032 Reset in RUN SHALL abort within the same edge; no further write and no done pulse.

Configuration
REQ-033 Macro CMD_RECT_CLIP_EN defined: pixels with col>=PANEL_WIDTH or row>=PANEL_HEIGHT (unwrapped sum) SHALL be skipped without write or idle cycle; fully off-panel rect goes to DONE with no writes.
REQ-034 Macro undefined: no clipping, wrap per REQ-027; clip logic absent.

Verification
REQ-035 FILL x1=2,y1=3,w=2,h=2,colour 0xABCD -> 8 writes: (3,2,1,AB),(3,2,0,CD),(3,3,1,AB),(3,3,0,CD),(4,2..3 same); done 1 cycle after last.
REQ-036 OUTLINE x1=0,y1=0,w=3,h=3 -> 8 pixels (16 writes), (1,1) never written.
REQ-037 w=0,h=5 -> zero writes, done pulse, ready_for_data high again.
REQ-038 x1=62,w=4,y1=0,h=1: CLIP_EN -> cols 62,63 only; no macro -> cols 62,63,0,1.
REQ-039 Reset asserted after 3rd write -> ram_write_enable 0 next cycle, no done, ready_for_data=1; next command executes correctly.
REQ-040 enable pulses during RUN -> ignored; write count and colour unchanged.
